// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit scheduler.
//   sched_state_t   : scheduler FSM encoding (3 bits)
//   UART_OVERSAMPLE : transmitter clocks per bit
//   UART_FRAME_CLKS : clocks per 10-bit frame at UART_OVERSAMPLE
// ----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        HOLD      = 3'd4,
        RECOVER   = 3'd5
    } sched_state_t;

    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_FRAME_CLKS = 10 * UART_OVERSAMPLE;

endpackage : uart_pkg

// File: rtl/uart_rr_pick.sv
// ----------------------------------------------------------------------------
// uart_rr_pick
// Combinational round-robin selector. Returns the first set bit of req,
// searching upward from ptr+1 and wrapping around.
//   req  [NUM_REQ] in  : candidate requests
//   ptr  [PTR_W]   in  : index of the most recently served requester
//   pick [NUM_REQ] out : one-hot winner, zero when req is zero
//   any            out : at least one request is present
// ----------------------------------------------------------------------------
module uart_rr_pick #(
    parameter int NUM_REQ = 4,
    localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] pick,
    output logic               any
);

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [2*NUM_REQ-1:0] req_rot_full;
    logic [2*NUM_REQ-1:0] oh_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic [NUM_REQ-1:0]   rot_oh;

    // Rotate so that requester ptr+1 sits at bit 0, isolate the lowest set
    // bit, then rotate the one-hot back. The doubled vector makes the
    // wrap-around a plain shift.
    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    always_comb begin
        req_dbl      = {req, req};
        req_rot_full = req_dbl >> (int'(ptr) + 1);
        req_rot      = req_rot_full[NUM_REQ-1:0];
        rot_oh       = req_rot & (~req_rot + NUM_REQ'(1));
        oh_dbl       = {rot_oh, rot_oh} << (int'(ptr) + 1);
        pick         = oh_dbl[2*NUM_REQ-1:NUM_REQ];
        any          = |req;
    end

endmodule : uart_rr_pick

// File: rtl/uart_tx_sched.sv
// ----------------------------------------------------------------------------
// uart_tx_sched
// Round-robin scheduler sharing one uart_tx between NUM_REQ byte requesters.
// A granted requester keeps the line until it sends a byte flagged last, so
// packets stay contiguous. A watchdog recovers a transmitter that never
// completes and releases an owner that stops supplying bytes mid-packet.
//
//   tx_clk, tx_rst_n         : clock (shared with uart_tx), async active-low reset
//   req_valid/req_last [N]   : per-requester byte offer and end-of-packet flag
//   req_data [8N]            : byte i is req_data[8i+7:8i]
//   req_ready [N]            : byte i accepted on this edge if req_valid[i]
//   grant [N]                : one-hot current owner, zero when unowned
//   uart_en/start/data       : to uart_tx tx_en / tx_start / tx_in
//   uart_busy/done           : from uart_tx tx_busy / tx_done (pulse)
//   err_timeout              : pulse when the transmitter watchdog fires
// ----------------------------------------------------------------------------
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 tx_clk,
    input  logic                 tx_rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 uart_en,
    output logic                 uart_start,
    output logic [7:0]           uart_data,
    input  logic                 uart_busy,
    input  logic                 uart_done,
    output logic                 err_timeout
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(NUM_REQ - 1);
    localparam logic [WD_W-1:0]  WD_MAX  = WD_W'(TIMEOUT_CYCLES);

    sched_state_t         state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [WD_W-1:0]      wdog_q, wdog_d;
    logic                 last_q, last_d;
    logic [7:0]           data_q, data_d;
    logic                 start_q, start_d;
    logic                 en_q, en_d;
    logic                 err_q, err_d;

    logic [NUM_REQ-1:0]   pick;
    logic                 any_req;
    logic [PTR_W-1:0]     owner_idx;
    logic [7:0]           owner_data;
    logic                 owner_last;
    logic                 owner_valid;
    logic                 wdog_exp;
    logic [WD_W-1:0]      wdog_inc;

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req  (req_valid),
        .ptr  (ptr_q),
        .pick (pick),
        .any  (any_req)
    );

    // Owner's lane of the request bus, selected by the one-hot grant.
    always_comb begin
        owner_idx  = '0;
        owner_data = '0;
        owner_last = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                owner_idx  = PTR_W'(i);
                owner_data = req_data[8*i +: 8];
                owner_last = req_last[i];
            end
        end
    end

    assign owner_valid = |(req_valid & grant_q);
    assign wdog_exp    = (wdog_q == WD_MAX);
    assign wdog_inc    = wdog_exp ? wdog_q : wdog_q + WD_W'(1);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        wdog_d  = wdog_q;
        last_d  = last_q;
        data_d  = data_q;
        start_d = start_q;
        en_d    = 1'b1;
        err_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d = pick;
                    state_d = LOAD;
                end
            end

            LOAD: begin
                if (owner_valid) begin
                    data_d  = owner_data;
                    last_d  = owner_last;
                    start_d = 1'b1;
                    wdog_d  = '0;
                    state_d = WAIT_BUSY;
                end else begin
                    state_d = HOLD;
                end
            end

            // uart_start stays high until the transmitter reports busy; this
            // also absorbs the transmitter's post-frame reset cycle.
            WAIT_BUSY: begin
                wdog_d = wdog_inc;
                if (uart_busy) begin
                    start_d = 1'b0;
                    state_d = WAIT_DONE;
                end else if (wdog_exp) begin
                    en_d    = 1'b0;
                    start_d = 1'b0;
                    err_d   = 1'b1;
                    grant_d = '0;
                    ptr_d   = owner_idx;
                    state_d = RECOVER;
                end
            end

            // uart_done is checked before expiry so a completion on the
            // expiry edge is never reported as an error.
            WAIT_DONE: begin
                wdog_d = wdog_inc;
                if (uart_done) begin
                    if (last_q) begin
                        grant_d = '0;
                        ptr_d   = owner_idx;
                        state_d = IDLE;
                    end else begin
                        wdog_d  = '0;
                        state_d = HOLD;
                    end
                end else if (wdog_exp) begin
                    en_d    = 1'b0;
                    start_d = 1'b0;
                    err_d   = 1'b1;
                    grant_d = '0;
                    ptr_d   = owner_idx;
                    state_d = RECOVER;
                end
            end

            // Mid-packet: keep the line for the owner, but give it up quietly
            // if the owner goes silent for too long.
            HOLD: begin
                wdog_d = wdog_inc;
                if (owner_valid) begin
                    state_d = LOAD;
                end else if (wdog_exp) begin
                    grant_d = '0;
                    ptr_d   = owner_idx;
                    state_d = IDLE;
                end
            end

            // Grant and pointer were already updated on entry; the registered
            // uart_en=0 / err_timeout=1 are visible for exactly this cycle.
            RECOVER: begin
                state_d = IDLE;
            end

            default: begin
                grant_d = '0;
                start_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge tx_clk or negedge tx_rst_n) begin
        if (!tx_rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= PTR_RST;
            wdog_q  <= '0;
            last_q  <= 1'b0;
            data_q  <= '0;
            start_q <= 1'b0;
            en_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            wdog_q  <= wdog_d;
            last_q  <= last_d;
            data_q  <= data_d;
            start_q <= start_d;
            en_q    <= en_d;
            err_q   <= err_d;
        end
    end

    assign req_ready   = grant_q & {NUM_REQ{state_q == LOAD}};
    assign grant       = grant_q;
    assign uart_en     = en_q;
    assign uart_start  = start_q;
    assign uart_data   = data_q;
    assign err_timeout = err_q;

endmodule : uart_tx_sched
